// File: rtl/audio_reset_pkg.sv
// audio_reset_pkg: shared state encoding and NCO defaults for the audio reset sequencer
package audio_reset_pkg;
  typedef enum logic [2:0] {IDLE, FILTER, HOLD, RELEASE, RUN} state_t;
  localparam int DEF_ACC_W = 32;
  function automatic logic [DEF_ACC_W-1:0] calc_tick_inc(input longint unsigned fs_hz, input longint unsigned clk_hz);
    return DEF_ACC_W'(((fs_hz << DEF_ACC_W) + clk_hz / 2) / clk_hz);
  endfunction
  localparam logic [DEF_ACC_W-1:0] DEF_TICK_INC = calc_tick_inc(48000, 40_000_000);
endpackage

// File: rtl/audio_reset_seq_sample_nco.sv
// sample_nco: fractional accumulator emitting a one-cycle tick after each carry-out
module sample_nco #(
  parameter int ACC_W = 32
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [ACC_W-1:0] increment,
  output logic             tick
);
  logic [ACC_W-1:0] acc, sum;
  logic carry;
  assign {carry, sum} = {1'b0, acc} + {1'b0, increment};
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      acc  <= '0;
      tick <= 1'b0;
    end else begin
      acc  <= enable ? sum : '0;
      tick <= enable & carry;
    end
endmodule

// File: rtl/audio_reset_seq.sv
// audio_reset_seq: lock-filtered, staged audio datapath resets plus a run-gated sample-rate tick
module audio_reset_seq
  import audio_reset_pkg::*;
#(
  parameter int GLITCH_FILT = 4,
  parameter int HOLD_CYCLES = 4000,
  parameter int STAGES      = 3,
  parameter int STAGE_GAP   = 16,
  parameter int ACC_W       = DEF_ACC_W,
  parameter logic [ACC_W-1:0] TICK_INC = ACC_W'(DEF_TICK_INC)
) (
  input  logic              clock_in,
  input  logic              rst_n_in,
  input  logic              locked_in,
  input  logic              soft_rst_in,
  input  logic              clr_status_in,
  output logic [STAGES-1:0] rst_out,
  output logic              ready_out,
  output logic              sample_tick_out,
  output logic              lock_lost_out,
  output logic [7:0]        lock_loss_cnt_out
);
  localparam int FW = $clog2(GLITCH_FILT + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(STAGE_GAP + 1);
  localparam int RW = $clog2(STAGES + 1);
  state_t state, state_d;
  logic [FW-1:0] flt_cnt, flt_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic [GW-1:0] gap_cnt, gap_d;
  logic [RW-1:0] rel, rel_d;
  logic [STAGES-1:0] rst_d;
  logic ready_d, loss, lost_d, abort, nco_en;
  logic [7:0] cnt_d;
  always_ff @(posedge clock_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state    <= IDLE;
      flt_cnt  <= '0;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      rel      <= '0;
    end else begin
      state    <= state_d;
      flt_cnt  <= flt_d;
      hold_cnt <= hold_d;
      gap_cnt  <= gap_d;
      rel      <= rel_d;
    end
  // rel counts released stages; it drives the reset mask directly
  always_comb begin
    state_d = state;
    flt_d   = flt_cnt;
    hold_d  = hold_cnt;
    gap_d   = gap_cnt;
    rel_d   = rel;
    abort   = state != IDLE && (!locked_in || soft_rst_in);
    case (state)
      IDLE: begin
        flt_d  = FW'(1);
        hold_d = '0;
        gap_d  = '0;
        rel_d  = '0;
        if (locked_in) state_d = GLITCH_FILT == 1 ? HOLD : FILTER;
      end
      FILTER: begin
        flt_d = flt_cnt + 1'b1;
        if (flt_cnt == FW'(GLITCH_FILT - 1)) state_d = HOLD;
      end
      HOLD: begin
        hold_d = hold_cnt + 1'b1;
        if (hold_cnt == HW'(HOLD_CYCLES)) begin
          state_d = RELEASE;
          rel_d   = RW'(1);
          gap_d   = '0;
        end
      end
      RELEASE: begin
        gap_d = gap_cnt + 1'b1;
        if (gap_cnt == GW'(STAGE_GAP - 1)) begin
          gap_d = '0;
          if (rel == RW'(STAGES)) state_d = RUN;
          else rel_d = rel + 1'b1;
        end
      end
      RUN: state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      rel_d   = '0;
    end
  end
  always_comb begin
    rst_d = '1;
    for (int k = 0; k < STAGES; k++) rst_d[k] = RW'(k) >= rel_d;
    ready_d = state_d == RUN;
    loss    = !locked_in && (state == RELEASE || state == RUN);
    lost_d  = clr_status_in ? 1'b0 : loss | lock_lost_out;
    cnt_d   = clr_status_in ? 8'd0 : (loss && lock_loss_cnt_out != 8'hff) ? lock_loss_cnt_out + 8'd1 : lock_loss_cnt_out;
    nco_en  = state == RUN && state_d == RUN;
  end
  always_ff @(posedge clock_in or negedge rst_n_in)
    if (!rst_n_in) begin
      rst_out           <= '1;
      ready_out         <= 1'b0;
      lock_lost_out     <= 1'b0;
      lock_loss_cnt_out <= '0;
    end else begin
      rst_out           <= rst_d;
      ready_out         <= ready_d;
      lock_lost_out     <= lost_d;
      lock_loss_cnt_out <= cnt_d;
    end
  sample_nco #(.ACC_W(ACC_W)) u_nco (
    .clock(clock_in),
    .rst_n(rst_n_in),
    .enable(nco_en),
    .increment(TICK_INC),
    .tick(sample_tick_out)
  );
endmodule

// File: tb/tb_audio_reset_seq.sv
// tb_audio_reset_seq: randomized and directed checks against a timeline model of the sequencer
module tb_audio_reset_seq;
  localparam int G = 4, H = 16, S = 3, GAP = 4;
  localparam longint unsigned INC = 64'd5153961;
  localparam int T_RUN = G + H + GAP * S;
  logic clk = 1'b0;
  logic rst_n_in = 1'b1, locked_in = 1'b0, soft_rst_in = 1'b0, clr_status_in = 1'b0;
  logic [S-1:0] rst_out;
  logic ready_out, sample_tick_out, lock_lost_out;
  logic [7:0] lock_loss_cnt_out;
  int nchk = 0, nerr = 0;
  bit m_act = 0, m_lost = 0;
  int m_t = 0, m_cnt = 0;
  always #5 clk = ~clk;
  audio_reset_seq #(.GLITCH_FILT(G), .HOLD_CYCLES(H), .STAGES(S), .STAGE_GAP(GAP)) dut (
    .clock_in(clk),
    .rst_n_in(rst_n_in),
    .locked_in(locked_in),
    .soft_rst_in(soft_rst_in),
    .clr_status_in(clr_status_in),
    .rst_out(rst_out),
    .ready_out(ready_out),
    .sample_tick_out(sample_tick_out),
    .lock_lost_out(lock_lost_out),
    .lock_loss_cnt_out(lock_loss_cnt_out)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic bit tick_at(input longint r);
    longint unsigned u = longint'(r);
    return r >= 1 && ((u * INC) >> 32) != (((u - 1) * INC) >> 32);
  endfunction
  // t counts edges since the first high lock sample; every output is a function of t
  function automatic logic [31:0] exp_vec();
    logic [S-1:0] r = '1;
    bit rdy = m_act && m_t >= T_RUN;
    for (int k = 0; k < S; k++) if (m_act && m_t >= G + H + GAP * k) r[k] = 1'b0;
    return {18'd0, r, rdy, m_act && tick_at(longint'(m_t - T_RUN)), m_lost, 8'(m_cnt)};
  endfunction
  function automatic logic [31:0] got_vec();
    return {18'd0, rst_out, ready_out, sample_tick_out, lock_lost_out, lock_loss_cnt_out};
  endfunction
  task automatic model_step(input bit l, input bit s, input bit c);
    bit loss = 0;
    if (!rst_n_in) begin
      m_act = 0; m_lost = 0; m_cnt = 0;
      return;
    end
    if (m_act) begin
      if (!l || s) begin
        loss = !l && m_t >= G + H;
        m_act = 0;
      end else m_t++;
    end else if (l) begin
      m_act = 1; m_t = 0;
    end
    if (c) begin
      m_lost = 0; m_cnt = 0;
    end else if (loss) begin
      m_lost = 1;
      if (m_cnt < 255) m_cnt++;
    end
  endtask
  task automatic cycle(input bit l, input bit s, input bit c);
    @(negedge clk);
    locked_in = l; soft_rst_in = s; clr_status_in = c;
    @(posedge clk);
    model_step(l, s, c);
    #1 check("cyc", got_vec(), exp_vec());
  endtask
  task automatic power_up(input string p);
    for (int i = 0; i <= T_RUN; i++) begin
      cycle(1, 0, 0);
      if (i == 19) check({p, "_pre"}, 32'(rst_out), 32'd7);
      if (i == 20) check({p, "_s0"}, 32'(rst_out), 32'd6);
      if (i == 24) check({p, "_s1"}, 32'(rst_out), 32'd4);
      if (i == 28) check({p, "_s2"}, 32'(rst_out), 32'd0);
      if (i == 31) check({p, "_rdy_pre"}, 32'(ready_out), 32'd0);
      if (i == 32) check({p, "_rdy"}, 32'(ready_out), 32'd1);
    end
  endtask
  initial begin
    int first, nticks, b2b;
    bit prev;
    #1 rst_n_in = 1'b0;
    #2 check("reset", got_vec(), {18'd0, 3'b111, 3'b000, 8'd0});
    repeat (3) cycle(0, 0, 0);
    @(negedge clk) rst_n_in = 1'b1;
    cycle(0, 0, 0);
    cycle(0, 1, 0);
    power_up("pu");
    repeat (5) cycle(1, 0, 0);
    cycle(0, 0, 0);
    check("ll_rst", 32'(rst_out), 32'd7);
    check("ll_rdy", 32'(ready_out), 32'd0);
    check("ll_flag", 32'(lock_lost_out), 32'd1);
    check("ll_cnt", 32'(lock_loss_cnt_out), 32'd1);
    power_up("relock");
    cycle(1, 0, 1);
    check("clr_cnt", 32'(lock_loss_cnt_out), 32'd0);
    check("clr_flag", 32'(lock_lost_out), 32'd0);
    cycle(0, 0, 0);
    repeat (3) cycle(1, 0, 0);
    cycle(0, 0, 0);
    for (int i = 0; i <= 20; i++) begin
      cycle(1, 0, 0);
      if (i == 19) check("gl_pre", 32'(rst_out), 32'd7);
      if (i == 20) check("gl_s0", 32'(rst_out), 32'd6);
    end
    check("gl_cnt", 32'(lock_loss_cnt_out), 32'd1);
    cycle(0, 0, 1);
    first = -1; nticks = 0; b2b = 0; prev = 0;
    for (int i = 0; i <= T_RUN + 20000; i++) begin
      cycle(1, 0, 0);
      if (sample_tick_out) begin
        if (first < 0) first = i - T_RUN;
        nticks++;
        if (prev) b2b++;
      end
      prev = sample_tick_out;
    end
    check("nco_first", 32'(first), 32'd834);
    check("nco_count", 32'(nticks), 32'((64'd20000 * INC) >> 32));
    check("nco_b2b", 32'(b2b), 32'd0);
    cycle(0, 0, 1);
    for (int i = 0; i <= G + H; i++) cycle(1, 0, 0);
    cycle(1, 1, 0);
    check("soft_rst", 32'(rst_out), 32'd7);
    check("soft_cnt", 32'(lock_loss_cnt_out), 32'd0);
    check("soft_flag", 32'(lock_lost_out), 32'd0);
    repeat (40) cycle(1, 0, 0);
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 63) != 0, $urandom_range(0, 127) == 0, $urandom_range(0, 63) == 0);
    cycle(0, 0, 1);
    for (int n = 0; n < 260; n++) begin
      for (int i = 0; i <= G + H + 1; i++) cycle(1, 0, 0);
      cycle(0, 0, 0);
    end
    check("sat", 32'(lock_loss_cnt_out), 32'd255);
    for (int i = 0; i <= 10; i++) cycle(1, 0, 0);
    #2 rst_n_in = 1'b0;
    #1 check("async_rst", got_vec(), {18'd0, 3'b111, 3'b000, 8'd0});
    model_step(1, 0, 0);
    repeat (2) cycle(1, 0, 0);
    @(negedge clk) rst_n_in = 1'b1;
    locked_in = 1'b0;
    power_up("rerun");
    repeat (50) cycle(1, 0, 0);
    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/audio_reset_seq.md
Name: audio_reset_seq

Overview:
- Sits directly downstream of the PLL wrapper, in the PLL output clock domain; consumes its synchronised `locked` flag.
- Produces ordered, staged active-high resets for the audio datapath: stage 0 sample source, stage 1 sigma-delta modulator, stage 2 4-bit DAC output.
- Produces a fractional-NCO sample-rate tick, 48 kHz nominal from 40 MHz, that runs only while the design is out of reset.
- Tracks PLL lock-loss events for debug.

Parameters:
- GLITCH_FILT, 4: consecutive cycles `locked_in` must be high before the hold-off starts (≥1).
- HOLD_CYCLES, 4000: hold-off cycles after filtering, 100 us at 40 MHz (≥1).
- STAGES, 3: number of staged reset outputs (1..8).
- STAGE_GAP, 16: cycles between successive stage releases (≥1).
- ACC_W, 32: NCO accumulator width.
- TICK_INC, 5153961: NCO increment, round(48000·2^32/40e6).

Ports:
- clock_in, input, 1: PLL output clock, buffered.
- rst_n_in, input, 1: asynchronous active-low reset.
- locked_in, input, 1: PLL lock, already synchronised to clock_in.
- soft_rst_in, input, 1: synchronous single-cycle request to re-run the full sequence.
- clr_status_in, input, 1: clears the lock-loss flag and counter.
- rst_out, output, STAGES: active-high reset per stage.
- ready_out, output, 1: all stages released.
- sample_tick_out, output, 1: one-cycle sample strobe.
- lock_lost_out, output, 1: sticky; set on lock loss after release began.
- lock_loss_cnt_out, output, 8: saturating count of lock-loss events.

Behaviour:
- **Reset.** While rst_n_in is low:
  - state = IDLE;
  - rst_out = all ones;
  - ready_out = 0, sample_tick_out = 0;
  - lock_lost_out = 0, lock_loss_cnt_out = 0;
  - NCO accumulator = 0.
- **Clocking.** All outputs are registered. No combinational path from any input to any output.
- **IDLE.** All resets asserted. Go to FILTER on the first edge at which locked_in = 1.
- **FILTER.**
  - locked_in = 0 → IDLE.
  - After GLITCH_FILT consecutive high samples (IDLE sample included) → HOLD.
- **HOLD.** Count HOLD_CYCLES, then → RELEASE.
  - Reference edge E0 = first edge sampling locked_in high.
  - rst_out[0] deasserts at edge E0 + GLITCH_FILT + HOLD_CYCLES.
- **RELEASE.**
  - rst_out[k] deasserts STAGE_GAP·k edges after rst_out[0].
  - Stages release in index order only.
  - STAGE_GAP edges after the last stage: ready_out = 1, state → RUN.
- **RUN.**
  - ready_out = 1.
  - Each cycle the accumulator adds TICK_INC modulo 2^ACC_W.
  - sample_tick_out = 1 on the cycle after a carry-out.
  - First tick occurs ceil(2^ACC_W / TICK_INC) cycles after entering RUN.
  - Ticks are never back-to-back while TICK_INC < 2^(ACC_W-1).
- **Lock loss.** locked_in = 0 in HOLD, RELEASE or RUN → IDLE on the next edge:
  - all rst_out reassert simultaneously;
  - ready_out = 0, sample_tick_out = 0, accumulator cleared.
  - In RELEASE or RUN only: lock_lost_out sets and lock_loss_cnt_out increments, saturating at 255.
- **soft_rst_in = 1** in any state other than IDLE: same as lock loss, except the status counters are untouched. In IDLE it is ignored.
- **Simultaneous events.**
  - Lock loss together with soft_rst_in counts as a lock loss.
  - clr_status_in in the same cycle as a lock-loss increment: clear wins, count = 0.
- **Mid-operation reset.** rst_n_in asserted in any state returns everything to reset values asynchronously. On deassertion the full sequence restarts.
- **Counter widths.** Counters are sized for the parameter maxima (clog2 of HOLD_CYCLES, STAGE_GAP, GLITCH_FILT). They never wrap inside a state.

Decomposition:
- Package audio_reset_pkg holds:
  - the state enum (IDLE, FILTER, HOLD, RELEASE, RUN);
  - the default TICK_INC and ACC_W constants;
  - a helper function computing TICK_INC from sample rate and clock frequency.
- One sub-module: sample_nco. Ports: clock, reset, enable, increment → tick. Enable low clears the accumulator.

Test Plan:
1. **Power-up sequence.** Bench overrides GLITCH_FILT=4, HOLD_CYCLES=16, STAGE_GAP=4, STAGES=3. locked_in rises at E0 → rst_out[0] low at E0+20, rst_out[1] low at E0+24, rst_out[2] low at E0+28, ready_out high at E0+32.
2. **Glitch filter.** locked_in high 3 cycles, low 1, then high → sequence restarts; rst_out[0] releases 20 edges after the second rise; lock_loss_cnt_out stays 0.
3. **Lock loss in RUN.** locked_in drops → next edge rst_out = 3'b111, ready_out = 0, lock_lost_out = 1, count = 1. Relock → full sequence repeats. clr_status_in → count 0, flag 0.
4. **NCO rate.** Defaults, RUN for 40,000,000 cycles → exactly 48000 ±1 ticks. First tick at cycle 834 after RUN entry. Every pulse is 1 cycle wide.
5. **soft_rst_in during RELEASE** (after stage 0 only) → all resets reassert next edge, status unchanged, sequence restarts from FILTER or IDLE per locked_in.
6. **Mid-sequence reset.** rst_n_in asserted mid-HOLD → outputs take reset values with no clock edge. Release → timing of scenario 1 repeats. Counter saturation: force 256 losses → count holds at 255.
